inst_encoder: RTL and testbench

INST_ENCODER -- requirements
Module: inst_encoder

---
 rtl/inst_encoder.sv | 161 ++++++++++++++++
 tb/tb_inst_encoder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Streams instruction descriptors into MIPS-I machine words and writes them
// to instruction memory, one registered write per accepted legal beat.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ovf,
  output logic [8:0]  count
);

  // state | meaning
  // IDLE  | waiting for start after reset
  // RUN   | accepting descriptors, emitting words
  // DONE  | program finished (last seen or 256 words written)
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] FMT_R = 2'd0;
  localparam logic [1:0] FMT_I = 2'd1;
  localparam logic [1:0] FMT_J = 2'd2;

  logic [1:0]  state;
  logic        last_pend;
  logic        legal;
  logic        accept;
  logic [1:0]  fmt;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [31:0] word;

  always_comb begin
    legal = 1'b1;
    fmt   = FMT_R;
    op    = 6'h00;
    func  = 6'h00;
    case (kind)
      5'd0:  func = 6'h20;
      5'd1:  func = 6'h21;
      5'd2:  func = 6'h22;
      5'd3:  func = 6'h23;
      5'd4:  func = 6'h24;
      5'd5:  func = 6'h25;
      5'd6:  func = 6'h26;
      5'd7:  func = 6'h27;
      5'd8:  func = 6'h2A;
      5'd9:  func = 6'h2B;
      5'd10: func = 6'h00;
      5'd11: func = 6'h02;
      5'd12: func = 6'h03;
      5'd13: func = 6'h08;
      5'd14: begin fmt = FMT_I; op = 6'h09; end
      5'd15: begin fmt = FMT_I; op = 6'h0A; end
      5'd16: begin fmt = FMT_I; op = 6'h0B; end
      5'd17: begin fmt = FMT_I; op = 6'h0C; end
      5'd18: begin fmt = FMT_I; op = 6'h0D; end
      5'd19: begin fmt = FMT_I; op = 6'h0E; end
      5'd20: begin fmt = FMT_I; op = 6'h0F; end
      5'd21: begin fmt = FMT_I; op = 6'h23; end
      5'd22: begin fmt = FMT_I; op = 6'h2B; end
      5'd23: begin fmt = FMT_I; op = 6'h04; end
      5'd24: begin fmt = FMT_I; op = 6'h05; end
      5'd25: begin fmt = FMT_J; op = 6'h02; end
      5'd26: begin fmt = FMT_J; op = 6'h03; end
      default: legal = 1'b0;
    endcase
  end

  // Field forcing: shifts drop rs, other R ops drop shamt, JR keeps only rs.
  always_comb begin
    word = 32'd0;
    case (fmt)
      FMT_R: begin
        if (kind >= 5'd10 && kind <= 5'd12)
          word = {6'h00, 5'd0, rt, rd, shamt, func};
        else if (kind == 5'd13)
          word = {6'h00, rs, 5'd0, 5'd0, 5'd0, func};
        else
          word = {6'h00, rs, rt, rd, 5'd0, func};
      end
      FMT_I:   word = {op, (kind == 5'd20) ? 5'd0 : rs, rt, imm};
      default: word = {op, target};
    endcase
  end

  // The in-flight write counts toward the 256-word limit.
  assign in_ready = (state == RUN) && !last_pend && !(count == 9'd255 && imem_we);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_pend  <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= 32'd0;
      imem_wdata <= 32'd0;
      count      <= 9'd0;
      err        <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          imem_we <= 1'b0;
          if (imem_we) begin
            imem_addr <= imem_addr + 32'd4;
            count     <= count + 9'd1;
            if (count == 9'd255) begin
              ovf   <= 1'b1;
              state <= DONE;
            end
          end
          if (last_pend) begin
            last_pend <= 1'b0;
            state     <= DONE;
          end
          if (accept) begin
            if (legal) begin
              imem_we    <= 1'b1;
              imem_wdata <= word;
            end else begin
              err <= 1'b1;
            end
            if (last) last_pend <= 1'b1;
          end
        end
        IDLE, DONE: begin
          imem_we <= 1'b0;
          if (start) begin
            state     <= RUN;
            imem_addr <= base_addr;
            count     <= 9'd0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            last_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: per-cycle comparison against a behavioural model
// plus literal checks of known machine words and boundary behaviour.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  kind, rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] target;
  logic        last;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wdata;
  logic        busy, done, err, ovf;
  logic [8:0]  count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .kind(kind), .rs(rs), .rt(rt),
    .rd(rd), .shamt(shamt), .imm(imm), .target(target), .last(last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .ovf(ovf), .count(count)
  );

  always #5 clk = ~clk;

  // Opcode / function tables indexed by kind.
  function automatic logic [31:0] enc(input logic [4:0] k, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [15:0] im, input logic [25:0] tg);
    logic [5:0] fn_tab [0:13];
    logic [5:0] op_tab [14:26];
    fn_tab = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08};
    op_tab = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23,
               6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};
    if (k <= 13) begin
      if (k == 13) return (32'(s) << 21) | 32'(fn_tab[k]);
      if (k >= 10) return (32'(t) << 16) | (32'(d) << 11) | (32'(sh) << 6) | 32'(fn_tab[k]);
      return (32'(s) << 21) | (32'(t) << 16) | (32'(d) << 11) | 32'(fn_tab[k]);
    end
    if (k <= 24) begin
      if (k == 20) s = 5'd0;
      return (32'(op_tab[k]) << 26) | (32'(s) << 21) | (32'(t) << 16) | 32'(im);
    end
    return (32'(op_tab[k]) << 26) | 32'(tg);
  endfunction

  // Model: words emitted so far, the word in flight, and the program status.
  bit          m_run, m_done, m_err, m_ovf, m_we, m_lastpend;
  logic [31:0] m_addr, m_word;
  int          m_count;

  function automatic bit exp_ready();
    return m_run && !m_lastpend && (m_count + int'(m_we)) < 256;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_done = 0; m_err = 0; m_ovf = 0; m_we = 0; m_lastpend = 0;
      m_addr = 0; m_word = 0; m_count = 0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_done = 0; m_err = 0; m_ovf = 0; m_we = 0; m_lastpend = 0;
        m_addr = base_addr; m_count = 0;
      end
    end else begin
      bit acc, finish;
      acc = exp_ready() && in_valid;
      finish = m_lastpend;
      if (m_we) begin
        m_count++;
        m_addr += 32'd4;
        if (m_count == 256) begin m_ovf = 1; finish = 1; end
      end
      m_we = 0;
      if (acc) begin
        if (kind < 27) begin m_we = 1; m_word = enc(kind, rs, rt, rd, shamt, imm, target); end
        else m_err = 1;
        if (last) m_lastpend = 1;
      end
      if (finish) begin m_run = 0; m_done = 1; m_lastpend = 0; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ready()));
      chk("imem_we", 32'(imem_we), 32'(m_we));
      chk("imem_addr", imem_addr, m_addr);
      if (m_we) chk("imem_wdata", imem_wdata, m_word);
      chk("count", 32'(count), 32'(m_count));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("err", 32'(err), 32'(m_err));
      chk("ovf", 32'(ovf), 32'(m_ovf));
    end
  end

  task automatic do_start(input logic [31:0] b);
    start = 1; base_addr = b;
    @(posedge clk); #1;
    start = 0;
  endtask

  // Presents a beat and returns just after the edge that accepts it.
  task automatic send(input logic [4:0] k, input logic [4:0] s, input logic [4:0] t,
      input logic [4:0] d, input logic [4:0] sh, input logic [15:0] im,
      input logic [25:0] tg, input logic l);
    int n;
    kind = k; rs = s; rt = t; rd = d; shamt = sh; imm = im; target = tg; last = l;
    in_valid = 1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 0; start = 0; base_addr = 0; in_valid = 0; kind = 0; rs = 0; rt = 0;
    rd = 0; shamt = 0; imm = 0; target = 0; last = 0;
    #1 chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // ADDIU single word
    do_start(32'h0040_0000);
    send(5'd14, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b0);
    chk("addiu_we", 32'(imem_we), 32'd1);
    chk("addiu_addr", imem_addr, 32'h0040_0000);
    chk("addiu_word", imem_wdata, 32'h2422_0005);
    // ADD then SLL back-to-back
    send(5'd0, 5'd1, 5'd2, 5'd3, 5'd9, 16'h0, 26'd0, 1'b0);
    chk("add_word", imem_wdata, 32'h0022_1820);
    chk("add_addr", imem_addr, 32'h0040_0004);
    send(5'd10, 5'd7, 5'd3, 5'd2, 5'd4, 16'h0, 26'd0, 1'b0);
    chk("sll_word", imem_wdata, 32'h0003_1100);
    chk("sll_addr", imem_addr, 32'h0040_0008);
    in_valid = 0;
    @(posedge clk); #1;
    chk("count3", 32'(count), 32'd3);
    // mixed kinds, illegal kind mid-stream
    send(5'd12, 5'd9, 5'd17, 5'd4, 5'd31, 16'h0, 26'd0, 1'b0);
    send(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1, 26'd1, 1'b0);
    in_valid = 0;
    @(posedge clk); #1;
    chk("err_set", 32'(err), 32'd1);
    send(5'd13, 5'd31, 5'd5, 5'd6, 5'd7, 16'h0, 26'd0, 1'b0);
    chk("jr_addr", imem_addr, 32'h0040_0010);
    chk("jr_word", imem_wdata, 32'h03E0_0008);
    send(5'd20, 5'd3, 5'd4, 5'd0, 5'd0, 16'hBEEF, 26'd0, 1'b0);
    send(5'd23, 5'd8, 5'd9, 5'd0, 5'd0, 16'hFFFC, 26'd0, 1'b0);
    send(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h3FF_FFFF, 1'b0);
    send(5'd22, 5'd29, 5'd31, 5'd0, 5'd0, 16'h8000, 26'd0, 1'b0);
    send(5'd21, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 1'b0);
    chk("lw_word", imem_wdata, 32'h8FA8_0004);
    send(5'd25, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0100, 1'b1);
    chk("j_word", imem_wdata, 32'h0800_0100);
    in_valid = 0;
    @(posedge clk); #1;
    chk("j_done", 32'(done), 32'd1);
    chk("j_ready", 32'(in_ready), 32'd0);
    repeat (2) @(posedge clk); #1;

    // illegal last beat ends the program
    do_start(32'h0000_0100);
    send(5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd0, 1'b1);
    in_valid = 0;
    repeat (2) @(posedge clk); #1;
    chk("illegal_last_done", 32'(done), 32'd1);

    // 256 words wrapping the address space, then a refused 257th beat
    do_start(32'hFFFF_FF00);
    for (int i = 0; i < 256; i++)
      send(5'(14 + (i % 13)), 5'(i), 5'(i + 3), 5'(i + 7), 5'(i), 16'(i * 97), 26'(i * 1031), 1'b0);
    repeat (4) @(posedge clk); #1;
    chk("full_count", 32'(count), 32'd256);
    chk("full_ovf", 32'(ovf), 32'd1);
    chk("full_done", 32'(done), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_addr", imem_addr, 32'h0000_0300);
    in_valid = 0;

    // reset during a pending write
    do_start(32'h0000_1000);
    send(5'd18, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0);
    in_valid = 0;
    chk("pend_we", 32'(imem_we), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr2", imem_addr, 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_flags", {28'd0, busy, done, err, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (5) @(posedge clk); #1;
    chk("post_rst_idle", 32'(busy), 32'd0);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
